// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 fetch stage.
package tiny16_pkg;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ADDR  = 2'd0,
      READ  = 2'd1,
      LATCH = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Memory-port, control and decode-handshake signals of the fetch stage.
interface fetch_unit_if;
   import tiny16_pkg::*;

   logic              bus_gnt;
   logic              bus_req;
   logic              mem_addr_en;
   logic [WORD_W-1:0] mem_addr;
   logic              mem_out_en;
   logic [WORD_W-1:0] mem_out;
   logic              pc_load;
   logic [WORD_W-1:0] pc_in;
   logic              halt;
   logic [WORD_W-1:0] ir;
   logic [WORD_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic [WORD_W-1:0] pc;

   modport master (
      input  bus_gnt, mem_out, pc_load, pc_in, halt, ir_ready,
      output bus_req, mem_addr_en, mem_addr, mem_out_en, ir, ir_pc, ir_valid, pc
   );

   modport slave (
      output bus_gnt, mem_out, pc_load, pc_in, halt, ir_ready,
      input  bus_req, mem_addr_en, mem_addr, mem_out_en, ir, ir_pc, ir_valid, pc
   );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: sync reset, load has priority over increment.
module pc_reg
   import tiny16_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_val,
   input  logic              inc,
   output logic [WORD_W-1:0] pc
);
   logic [WORD_W-1:0] pc_d;
   logic [WORD_W-1:0] pc_q;

   // next PC: jump target beats increment; increment wraps at 16 bits
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + 16'd1;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC storage
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// tiny16 instruction fetch: sequences the shared memory port, captures IR
// and hands it to decode over a valid/ready handshake.
module fetch_unit
   import tiny16_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   fetch_state_t      state_d, state_q;
   logic [WORD_W-1:0] ir_d, ir_q;
   logic [WORD_W-1:0] ir_pc_d, ir_pc_q;
   logic              ir_valid_d, ir_valid_q;
   logic              pc_ld_s, pc_inc_s;
   logic              addr_en_s, out_en_s, req_s;
   logic [WORD_W-1:0] pc_s;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_ld_s),
      .load_val (bus.pc_in),
      .inc      (pc_inc_s),
      .pc       (pc_s)
   );

   // port request follows the state alone; released in LATCH/HOLD
   always_comb begin
      req_s = 1'b0;
      case (state_q)
         ADDR:    req_s = !bus.halt;
         READ:    req_s = 1'b1;
         default: req_s = 1'b0;
      endcase
   end

   // next-state, memory enables and IR update; a jump flushes everything
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      pc_ld_s    = 1'b0;
      pc_inc_s   = 1'b0;
      addr_en_s  = 1'b0;
      out_en_s   = 1'b0;
      if (bus.pc_load) begin
         pc_ld_s    = 1'b1;
         ir_valid_d = 1'b0;
         state_d    = ADDR;
      end else begin
         case (state_q)
            ADDR: begin
               if (!bus.halt && bus.bus_gnt) begin
                  addr_en_s = 1'b1;
                  state_d   = READ;
               end else begin
                  state_d = ADDR;
               end
            end
            READ: begin
               // losing the grant here may have clobbered MAR, so re-issue
               if (bus.bus_gnt) begin
                  out_en_s = 1'b1;
                  state_d  = LATCH;
               end else begin
                  state_d = ADDR;
               end
            end
            LATCH: begin
               ir_d       = bus.mem_out;
               ir_pc_d    = pc_s;
               pc_inc_s   = 1'b1;
               ir_valid_d = 1'b1;
               state_d    = HOLD;
            end
            HOLD: begin
               if (ir_valid_q && bus.ir_ready) begin
                  ir_valid_d = 1'b0;
                  state_d    = ADDR;
               end else begin
                  state_d = HOLD;
               end
            end
            default: state_d = ADDR;
         endcase
      end
   end

   // state and instruction register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ADDR;
         ir_q       <= 16'h0000;
         ir_pc_q    <= 16'h0000;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   // reset silences the port even though ADDR would otherwise issue
   assign bus.mem_addr_en = addr_en_s & !rst;
   assign bus.mem_out_en  = out_en_s & !rst;
   assign bus.bus_req     = req_s & !rst;
   assign bus.mem_addr    = pc_s;
   assign bus.ir          = ir_q;
   assign bus.ir_pc       = ir_pc_q;
   assign bus.ir_valid    = ir_valid_q;
   assign bus.pc          = pc_s;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for tiny16.
- Holds the program counter (PC) and sequences the memory block's address-latch and read enables to fetch one 16-bit instruction word.
- Captures the word into an instruction register (IR) and presents it to decode over a valid/ready handshake.
- Shares the memory port with the data path via a grant input; handles jumps (PC load) and halt.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- WORD_W, 16, instruction/address width (fixed at 16; not for override).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bus_gnt  input  1  fetch may drive memory enables this cycle
- bus_req  output  1  fetch requests the memory port
- mem_addr_en  output  1  to memory addr_en (latch MAR)
- mem_addr  output  16  to memory addr
- mem_out_en  output  1  to memory out_en (registered read of mem[MAR])
- mem_out  input  16  from memory out
- pc_load  input  1  jump: replace PC, flush fetch
- pc_in  input  16  jump target
- halt  input  1  stop starting new fetches
- ir  output  16  fetched instruction
- ir_pc  output  16  address ir was fetched from
- ir_valid  output  1  ir holds an unconsumed instruction
- ir_ready  input  1  decode accepts ir
- pc  output  16  current PC (next fetch address)

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0.
  - State ADDR; all memory enables 0; bus_req=0.
  - Reset overrides every other input, including mid-fetch.
- Memory timing contract:
  - addr_en at cycle t latches MAR at t.
  - out_en at t+1 registers mem[MAR].
  - mem_out is valid in cycle t+2.
- FSM states: ADDR, READ, LATCH, HOLD.
- ADDR:
  - bus_req=!halt; mem_addr=pc (combinational).
  - If !halt && bus_gnt: mem_addr_en=1, go READ. Otherwise stay, no enables.
- READ:
  - bus_req=1.
  - If bus_gnt: mem_out_en=1, go LATCH.
  - If !bus_gnt: return to ADDR. MAR may have been overwritten by another master, so the address is re-issued.
- LATCH:
  - No enables; bus_req=0.
  - ir<=mem_out, ir_pc<=pc, pc<=pc+1 (16-bit, FFFF wraps to 0000), ir_valid<=1.
  - Go HOLD.
- HOLD:
  - ir, ir_pc and ir_valid stable.
  - On ir_valid && ir_ready: ir_valid<=0, go ADDR.
- Latency: ADDR (with grant) to ir_valid high is 3 cycles. Peak throughput is 1 instruction per 4 cycles with ir_ready held high.
- mem_addr_en and mem_out_en are never both 1 in the same cycle. Both are 0 whenever bus_gnt=0.
- pc_load (any state, highest priority after rst):
  - pc<=pc_in, ir_valid<=0, state<=ADDR.
  - No enables issued that cycle; any in-flight read is discarded.
  - If pc_load coincides with an ir_valid&&ir_ready handshake, the handshake counts as accepted and the PC still loads.
  - pc_load in LATCH: the pc_in value wins over pc+1, and ir is not updated.
- halt: only blocks the ADDR→READ transition. An in-progress fetch completes and presents in HOLD. Deasserting halt resumes from the current pc.
- bus_req is low in LATCH and HOLD, releasing the port for data accesses.

Decomposition:
- Package tiny16_pkg:
  - WORD_W=16.
  - Enum fetch_state_t {ADDR, READ, LATCH, HOLD}.
  - RESET_PC default constant, shared with the top-level.
- Sub-module pc_reg: 16-bit register with sync reset to RESET_PC, load (priority) and increment enable. Everything else stays in fetch_unit.

Test Plan:
- Preload mem[0]=16'h1234, mem[1]=16'hABCD. Reset, then bus_gnt=1, ir_ready=1 → ir=1234/ir_pc=0 at cycle 4 after reset release; ir=ABCD/ir_pc=1 four cycles later; pc=2.
- ir_ready=0 after the first fetch → ir_valid stays 1 and ir=1234 held for 10 cycles, with no memory enables. Raise ir_ready → next fetch of 0x0001 starts the cycle after the handshake.
- Drop bus_gnt in the READ cycle for 2 cycles → mem_out_en not asserted, FSM returns to ADDR, mem_addr_en is re-issued with addr=0 once bus_gnt=1, and the correct word is fetched.
- pc_load=1, pc_in=16'h0080 during LATCH of the fetch at 0 → ir_valid stays 0, pc=0080, next mem_addr=0080; preloaded mem[0x80]=16'h5A5A appears on ir with ir_pc=0080.
- pc_load pc_in=16'hFFFF, mem[FFFF mod size] preloaded → after the fetch, pc wraps to 0000.
- halt=1 in READ → the fetch completes (ir_valid=1), then after the handshake no further mem_addr_en until halt=0. Assert rst in READ → next cycle pc=RESET_PC, ir_valid=0, enables 0.
